// File: rtl/matrix_operand_feeder_if.sv
// Bus between the operand feeder and its controller.
// Write port, run request and the registered operand stream toward the multiplier.
interface matrix_operand_feeder_if #(
  parameter int DW = 8
);
  logic          WR_EN;
  logic          WR_SEL;
  logic [1:0]    WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          GO;
  logic          BUSY;
  logic          DONE;
  logic          START;
  logic [DW-1:0] A_OUT;
  logic [DW-1:0] B_OUT;
  logic [1:0]    RES_IDX;

  modport master (
    output WR_EN, WR_SEL, WR_ADDR, WR_DATA, GO,
    input  BUSY, DONE, START, A_OUT, B_OUT, RES_IDX
  );

  modport slave (
    input  WR_EN, WR_SEL, WR_ADDR, WR_DATA, GO,
    output BUSY, DONE, START, A_OUT, B_OUT, RES_IDX
  );
endinterface

// File: rtl/matrix_operand_feeder.sv
// Stores 2x2 operand matrices A/B and streams the eight (A[i][k], B[k][j]) pairs on the
// multiplier's fixed sampling cadence. Optional FEEDER_ZERO_IDLE_EN zeroes operands outside RUN.
module matrix_operand_feeder #(
  parameter int DW  = 8,
  parameter int CYC = 3
) (
  input  logic                   CLK,
  input  logic                   NRST,
  matrix_operand_feeder_if.slave bus
);
  localparam int PHW = $clog2(CYC);

  typedef enum logic [2:0] {IDLE, STRT, SYNC, RUN, DONE_S} state_t;

  state_t         state;
  logic [DW-1:0]  ram_a [4];
  logic [DW-1:0]  ram_b [4];
  logic           started;
  logic [PHW-1:0] ph;
  logic           par;
  logic [2:0]     pair;
  logic           busy;
  logic           done;
  logic           start;
  logic [DW-1:0]  a_out;
  logic [DW-1:0]  b_out;
  logic [1:0]     res_idx;

  logic           ph_wrap;
  logic [2:0]     ld_idx;
  logic [DW-1:0]  ld_a;
  logic [DW-1:0]  ld_b;

  assign ph_wrap = (ph == PHW'(CYC - 1));

  // Pair n = {i,j,k}: A index {i,k}, B index {k,j}.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    ld_idx = 3'd0;
    if (state == RUN) ld_idx = pair + 3'd1;
    ld_a = ram_a[{ld_idx[2], ld_idx[0]}];
    ld_b = ram_b[{ld_idx[0], ld_idx[1]}];
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      // NOTE: the operand RAM is reset on purpose; a run after reset must stream zeros.
      for (int k = 0; k < 4; k++) begin
        ram_a[k] <= '0;
        ram_b[k] <= '0;
      end
    end else if (state == IDLE && bus.WR_EN) begin
      if (bus.WR_SEL) ram_b[bus.WR_ADDR] <= bus.WR_DATA;
      else            ram_a[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
      state   <= IDLE;
      started <= 1'b0;
      ph      <= '0;
      par     <= 1'b0;
      pair    <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      start   <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      res_idx <= 2'd0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;

      // Mirror of the multiplier's sample phase; runs forever once START has been issued.
      if (started) begin
        ph <= ph_wrap ? '0 : ph + PHW'(1);
        if (ph_wrap) par <= ~par;
      end

      case (state)
        IDLE: begin
          if (bus.GO) begin
            busy <= 1'b1;
            if (started) begin
              state <= SYNC;
            end else begin
              state <= STRT;
              start <= 1'b1;
            end
          end
        end

        STRT: begin
          started <= 1'b1;
          ph      <= '0;
          par     <= 1'b0;
          state   <= RUN;
          pair    <= 3'd0;
          a_out   <= ld_a;
          b_out   <= ld_b;
          res_idx <= 2'd0;
        end

        SYNC: begin
          // Enter RUN so pair 0 lands on the first product of an output.
          if (ph_wrap && par) begin
            state   <= RUN;
            pair    <= 3'd0;
            a_out   <= ld_a;
            b_out   <= ld_b;
            res_idx <= 2'd0;
          end
        end

        RUN: begin
          if (ph_wrap) begin
            if (pair == 3'd7) begin
              state <= DONE_S;
              done  <= 1'b1;
              busy  <= 1'b0;
`ifdef FEEDER_ZERO_IDLE_EN
              a_out <= '0;
              b_out <= '0;
`endif
            end else begin
              pair    <= ld_idx;
              a_out   <= ld_a;
              b_out   <= ld_b;
              res_idx <= {ld_idx[2], ld_idx[1]};
            end
          end
        end

        DONE_S: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.START   = start;
  assign bus.A_OUT   = a_out;
  assign bus.B_OUT   = b_out;
  assign bus.RES_IDX = res_idx;
endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Bench for matrix_operand_feeder: cycle-accurate expectations from matrix indices and sample
// cadence arithmetic, plus a downstream multiplier model accumulating results.
module tb_matrix_operand_feeder;
  localparam int DW = 8;
`ifdef FEEDER_ZERO_IDLE_EN
  localparam bit ZERO_IDLE = 1'b1;
`else
  localparam bit ZERO_IDLE = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic NRST = 1'b0;

  matrix_operand_feeder_if #(.DW(DW)) bus();

  matrix_operand_feeder #(.DW(DW), .CYC(3)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c1    = 0;
  bit m_started = 1'b0;
  int m_acc = 0;
  int res_q[$];
  int ma[4];
  int mb[4];
  int last_a = 0;
  int last_b = 0;

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sa(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int c_exp(input int i, input int j);
    return ma[i*2] * mb[j] + ma[i*2+1] * mb[2+j];
  endfunction

  // Downstream multiplier: samples every 3rd edge after START, pairs products into results.
  always @(posedge CLK) begin
    int rel;
    int prod;
    cyc <= cyc + 1;
    if (m_started && NRST) begin
      rel = cyc - c1;
      if (rel >= 0 && rel % 3 == 0) begin
        prod = sa(bus.A_OUT) * sa(bus.B_OUT);
        if ((rel / 3) % 2 == 0) m_acc = prod;
        else res_q.push_back(m_acc + prod);
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input int val);
    bus.WR_EN   = 1'b1;
    bus.WR_SEL  = sel;
    bus.WR_ADDR = 2'(addr);
    bus.WR_DATA = 8'(val);
    @(posedge CLK); #1;
    bus.WR_EN = 1'b0;
    if (sel) mb[addr] = val;
    else     ma[addr] = val;
  endtask

  task automatic load(input int a[4], input int b[4]);
    for (int k = 0; k < 4; k++) wr(1'b0, k, a[k]);
    for (int k = 0; k < 4; k++) wr(1'b1, k, b[k]);
  endtask

  // Raises GO and follows the run cycle by cycle; ends at the negedge of the DONE cycle.
  task automatic do_run(input bit exp_start, input int abort_pair, input bit poke);
    int e0;
    int d;
    int rel;
    bus.GO = 1'b1;
    @(posedge CLK); #1;
    bus.GO = 1'b0;
    e0 = cyc;
    if (exp_start) begin
      d = 1;
      m_started = 1'b1;
      c1 = e0 + 1;
    end else begin
      d = 6;
      for (int k = 6; k >= 1; k--) begin
        rel = e0 + k - c1;
        if (rel % 3 == 0 && (rel / 3) % 2 == 0) d = k;
      end
    end

    for (int k = 0; k < d; k++) begin
      @(negedge CLK);
      check("start", int'(bus.START), int'(exp_start && k == 0));
      check("busy_wait", int'(bus.BUSY), 1);
      check("a_wait", sa(bus.A_OUT), last_a);
      check("b_wait", sa(bus.B_OUT), last_b);
    end

    for (int n = 0; n < 8; n++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge CLK);
        if (n == 0 && s == 0) res_q.delete();
        if (n == abort_pair && s == 1) begin
          NRST = 1'b0;
          #1;
          check("rst_busy", int'(bus.BUSY), 0);
          check("rst_done", int'(bus.DONE), 0);
          check("rst_start", int'(bus.START), 0);
          check("rst_a", sa(bus.A_OUT), 0);
          check("rst_b", sa(bus.B_OUT), 0);
          check("rst_idx", int'(bus.RES_IDX), 0);
          m_started = 1'b0;
          for (int k = 0; k < 4; k++) begin
            ma[k] = 0;
            mb[k] = 0;
          end
          last_a = 0;
          last_b = 0;
          repeat (2) @(negedge CLK);
          check("rst_hold_a", sa(bus.A_OUT), 0);
          NRST = 1'b1;
          return;
        end
        check("pair_a", sa(bus.A_OUT), ma[(n/4)*2 + n%2]);
        check("pair_b", sa(bus.B_OUT), mb[(n%2)*2 + (n/2)%2]);
        check("res_idx", int'(bus.RES_IDX), n / 2);
        check("busy_run", int'(bus.BUSY), 1);
        check("start_run", int'(bus.START), 0);
        check("done_run", int'(bus.DONE), 0);
        if (poke && n == 2) begin
          if (s == 0) begin
            bus.WR_EN   = 1'b1;
            bus.WR_SEL  = 1'b0;
            bus.WR_ADDR = 2'd0;
            bus.WR_DATA = 8'd99;
            bus.GO      = 1'b1;
          end else if (s == 1) begin
            bus.WR_EN = 1'b0;
            bus.GO    = 1'b0;
          end
        end
      end
    end

    last_a = ZERO_IDLE ? 0 : ma[3];
    last_b = ZERO_IDLE ? 0 : mb[3];
    @(negedge CLK);
    check("done", int'(bus.DONE), 1);
    check("busy_done", int'(bus.BUSY), 0);
    check("a_done", sa(bus.A_OUT), last_a);
    check("b_done", sa(bus.B_OUT), last_b);
    check("res_count", res_q.size(), 4);
    for (int r = 0; r < 4 && r < res_q.size(); r++)
      check($sformatf("result%0d", r), res_q[r], c_exp(r / 2, r % 2));
  endtask

  initial begin
    int ra[4];
    int rb[4];
    bus.GO = 1'b0;
    bus.WR_EN = 1'b0;
    bus.WR_SEL = 1'b0;
    bus.WR_ADDR = 2'd0;
    bus.WR_DATA = '0;
    for (int k = 0; k < 4; k++) begin
      ma[k] = 0;
      mb[k] = 0;
    end

    repeat (3) @(negedge CLK);
    check("reset_busy", int'(bus.BUSY), 0);
    check("reset_done", int'(bus.DONE), 0);
    check("reset_start", int'(bus.START), 0);
    check("reset_a", sa(bus.A_OUT), 0);
    check("reset_b", sa(bus.B_OUT), 0);
    check("reset_idx", int'(bus.RES_IDX), 0);
    NRST = 1'b1;
    @(posedge CLK); #1;

    // Basic run, then GO in the DONE cycle (ignored) and again in the next cycle.
    load('{1, 2, 3, 4}, '{5, 6, 7, 8});
    do_run(1'b1, -1, 1'b0);
    bus.GO = 1'b1;
    @(posedge CLK); #1;
    check("go_in_done_busy", int'(bus.BUSY), 0);
    check("idle_a", sa(bus.A_OUT), ZERO_IDLE ? 0 : 4);
    check("idle_b", sa(bus.B_OUT), ZERO_IDLE ? 0 : 8);
    do_run(1'b0, -1, 1'b0);
    @(posedge CLK); #1;

    // Write attempt and GO during RUN are ignored; the next run still sees A[0][0]=1.
    do_run(1'b0, -1, 1'b1);
    @(posedge CLK); #1;
    do_run(1'b0, -1, 1'b0);
    @(posedge CLK); #1;

    load('{-128, -128, -128, -128}, '{-128, -128, -128, -128});
    do_run(1'b0, -1, 1'b0);
    @(posedge CLK); #1;

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge CLK); #1;
      end
      for (int k = 0; k < 4; k++) begin
        ra[k] = int'($urandom_range(0, 255)) - 128;
        rb[k] = int'($urandom_range(0, 255)) - 128;
      end
      load(ra, rb);
      do_run(1'b0, -1, 1'b0);
      @(posedge CLK); #1;
    end

    // Reset during pair 3, then a fresh run must re-issue START with a zeroed RAM.
    do_run(1'b0, 3, 1'b0);
    do_run(1'b1, -1, 1'b0);
    @(posedge CLK); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matrix_operand_feeder.md
# matrix_operand_feeder

Upstream stage of the 2x2 signed matrix multiplier datapath. It stores two 2x2 matrices of 8-bit signed operands (A and B) written over a simple write port. On GO it issues the multiplier's one-time START pulse and streams the eight operand pairs on A_OUT/B_OUT, each pair aligned to the multiplier's fixed 3-cycle sampling cadence. It keeps that cadence and the 2-product result parity across back-to-back runs.

## Interface
- DW, 8, operand width; A_OUT/B_OUT are two's-complement DW bits.
- CYC, 3, cycles between downstream operand samples; fixed by the multiplier's S1/S2/S3 loop.
- CLK  in  1  clock; all state updates on posedge.
- NRST  in  1  reset, asynchronous, active-low.
- WR_EN  in  1  write strobe for the operand RAM.
- WR_SEL  in  1  0 = matrix A, 1 = matrix B.
- WR_ADDR  in  2  row-major index {row,col}.
- WR_DATA  in  DW  signed operand.
- GO  in  1  run request, level sampled.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse after the last pair window.
- START  out  1  one-cycle pulse to the multiplier.
- A_OUT  out  DW  row operand to the multiplier.
- B_OUT  out  DW  column operand to the multiplier.
- RES_IDX  out  2  {i,j} of the result whose pairs are currently driven.

## Operation
- Reset values: BUSY=0, DONE=0, START=0, A_OUT=0, B_OUT=0, RES_IDX=0. Operand RAM cleared to 0. Internal flags cleared: `started`, phase counter `ph` (0..2), slot parity `par`.
- Downstream model: after START, the multiplier samples A_OUT*B_OUT once every CYC cycles, forever, until NRST. Every second sample completes one dot-product output. `ph==0` marks the cycle whose closing edge is a sample edge. `par` toggles each time `ph` wraps 2->0; `par==0` marks the first product of an output.
- FSM states:
  - IDLE: WR_EN writes RAM[WR_SEL][WR_ADDR]. GO=1 moves to SYNC (if `started`) or to STRT (if not).
  - STRT: START=1 for one cycle. Set `started`, `ph`=0, `par`=0, then go to RUN.
  - SYNC: wait until the coming cycle has `ph==0 && par==0`, then go to RUN.
  - RUN: drive pair n = (A[i][k], B[k][j]) for CYC cycles each. Order is i outer, j, k inner, n=0..7. After pair 7's window, go to DONE_S.
  - DONE_S: DONE=1 for one cycle, then IDLE.
- `ph` and `par` free-run from STRT onward in every state, including IDLE and SYNC.
- RES_IDX={i,j} updates with the pair.
- BUSY=1 in STRT, SYNC and RUN. BUSY=0 in IDLE and DONE_S.
- WR_EN while BUSY or in DONE_S: ignored, RAM unchanged.
- GO while BUSY: ignored.
- GO held high in DONE_S: not accepted until IDLE.
- Pure data movement, no arithmetic. Operand bits pass through unchanged.
- Reset mid-run: all state returns to reset values immediately. The next GO re-issues START, since the multiplier shares NRST.

## Timing
- Number edges from E0, the edge sampling GO in IDLE.
- First run after reset: START high in cycle [E0,E1). Pair n is driven in cycles [E1+3n, E4+3n) and sampled downstream at E2+3n. DONE is high in [E25,E26).
- Later runs: first pair starts 1 to 6 cycles after E0, at the next cycle with `ph==0 && par==0`. The run length after that is identical.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FEEDER_ZERO_IDLE_EN defined: A_OUT/B_OUT are forced to 0 outside RUN, so the free-running multiplier produces 0 results between runs.
- Not defined: A_OUT/B_OUT hold the last driven pair outside RUN (fewer toggles); downstream results between runs are don't-care.

## Test plan
- Basic run:
  - Stimulus: write A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse GO.
  - Required: START one cycle after GO; pairs (1,5),(2,7),(1,6),(2,8),(3,5),(4,7),(3,6),(4,8), each held exactly 3 cycles; multiplier strobes 19, 22, 43, 50; DONE 25 cycles after GO.
- Extreme values:
  - Stimulus: all operands -128.
  - Required: A_OUT/B_OUT = 8'h80 throughout; multiplier outputs 32768 four times, with no sign error.
- Back-to-back runs:
  - Stimulus: GO in the DONE cycle and again in the following cycle.
  - Required: the first GO is ignored. The second run issues no START and starts pairs on the next `ph==0`, `par==0` cycle. Results still pair correctly (19, 22, 43, 50 again).
- Write protection:
  - Stimulus: WR_EN with WR_SEL=0, WR_ADDR=0, WR_DATA=99 during RUN.
  - Required: the current run and the next run both use A[0][0]=1.
- Reset mid-run:
  - Stimulus: NRST low during pair 3, then release and pulse GO.
  - Required: all outputs are 0 during reset; START is re-issued; the run completes with the RAM reset to zeros (all results 0).
- Macro check:
  - With FEEDER_ZERO_IDLE_EN: A_OUT=B_OUT=0 in IDLE after a run.
  - Without it: both hold 4 and 8 after the basic run.
